// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: owns the h/v scan counters, aligns the producer colour with blank/sync decode, drives registered pins.
// Latency from H_CNT to pins is PRODUCER_LAT+1 enabled cycles; PIX_EN=0 stalls every stage and holds the pins.
module vga_scan_driver #(
  parameter int H_CNT_WID    = 10,
  parameter int V_CNT_WID    = 10,
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int PRODUCER_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 PIX_EN,
  output logic [H_CNT_WID-1:0] H_CNT,
  output logic [V_CNT_WID-1:0] next_V_CNT,
  output logic                 NEXT_FRAME,
  output logic                 H_BLANKING,
  input  logic [3:0]           r,
  input  logic [3:0]           g,
  input  logic [3:0]           b,
  output logic [3:0]           VGA_R,
  output logic [3:0]           VGA_G,
  output logic [3:0]           VGA_B,
  output logic                 VGA_HSYNC,
  output logic                 VGA_VSYNC
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [H_CNT_WID-1:0] H_LAST     = H_CNT_WID'(H_TOTAL - 1);
  localparam logic [H_CNT_WID-1:0] H_VIS      = H_CNT_WID'(H_VISIBLE);
  localparam logic [H_CNT_WID-1:0] H_SYNC_BEG = H_CNT_WID'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_WID-1:0] H_SYNC_END = H_CNT_WID'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_CNT_WID-1:0] V_LAST     = V_CNT_WID'(V_TOTAL - 1);
  localparam logic [V_CNT_WID-1:0] V_VIS      = V_CNT_WID'(V_VISIBLE);
  localparam logic [V_CNT_WID-1:0] V_SYNC_BEG = V_CNT_WID'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_WID-1:0] V_SYNC_END = V_CNT_WID'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [H_CNT_WID-1:0] r_h;
  logic [V_CNT_WID-1:0] r_v;
  logic                 w_h_last;
  logic                 w_v_last;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_h <= '0;
      r_v <= '0;
    end else if (PIX_EN) begin
      r_h <= w_h_last ? '0 : r_h + 1'b1;
      if (w_h_last) begin
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end
    end
  end

  assign H_CNT      = r_h;
  assign H_BLANKING = (r_h >= H_VIS);
  assign next_V_CNT = w_v_last ? '0 : r_v + 1'b1;
  assign NEXT_FRAME = PIX_EN && (r_h == '0) && (r_v == V_VIS);

  // Decode bundle {active, hs_act, vs_act}; it travels alongside the producer's pipeline.
  logic [2:0] w_stage_in;
  logic [2:0] w_stage_out;

  assign w_stage_in = {(r_h < H_VIS) && (r_v < V_VIS),
                       (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END),
                       (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END)};

  generate
    if (PRODUCER_LAT == 0) begin : g_no_dly
      assign w_stage_out = w_stage_in;
    end else begin : g_dly
      logic [PRODUCER_LAT-1:0][2:0] r_pipe;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_pipe <= '0;
        end else if (PIX_EN) begin
          r_pipe[0] <= w_stage_in;
          for (int i = 1; i < PRODUCER_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_stage_out = r_pipe[PRODUCER_LAT-1];
    end
  endgenerate

  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rgb   <= '0;
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
    end else if (PIX_EN) begin
      r_rgb   <= w_stage_out[2] ? {r, g, b} : 12'd0;
      r_hsync <= w_stage_out[1] ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_stage_out[0] ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign VGA_R     = r_rgb[11:8];
  assign VGA_G     = r_rgb[7:4];
  assign VGA_B     = r_rgb[3:0];
  assign VGA_HSYNC = r_hsync;
  assign VGA_VSYNC = r_vsync;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: default 640x480 instance and a tiny-raster instance share clock, reset, enable and colour.
// Expected values come from the count of enabled edges since reset, decomposed into raster positions.
module tb_vga_scan_driver;

  localparam int DH_VIS = 640, DH_FR = 16, DH_SY = 96, DH_BK = 48;
  localparam int DV_VIS = 480, DV_FR = 10, DV_SY = 2,  DV_BK = 33;
  localparam int D_LAT  = 1;
  localparam int DH_TOT = DH_VIS + DH_FR + DH_SY + DH_BK;
  localparam int DV_TOT = DV_VIS + DV_FR + DV_SY + DV_BK;

  localparam int SH_VIS = 4, SH_FR = 1, SH_SY = 1, SH_BK = 1;
  localparam int SV_VIS = 3, SV_FR = 1, SV_SY = 1, SV_BK = 1;
  localparam int S_LAT  = 2;
  localparam int SH_TOT = SH_VIS + SH_FR + SH_SY + SH_BK;
  localparam int SV_TOT = SV_VIS + SV_FR + SV_SY + SV_BK;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       PIX_EN;
  logic [3:0] r, g, b;

  logic [9:0] d_hcnt, d_nextv, s_hcnt, s_nextv;
  logic       d_nf, d_hblank, d_hs, d_vs, s_nf, s_hblank, s_hs, s_vs;
  logic [3:0] d_vr, d_vg, d_vb, s_vr, s_vg, s_vb;

  int          total = 0;
  int          bad = 0;
  int          n = 0;
  bit          cur_en = 1'b0;
  logic [11:0] pend_rgb = '0;
  logic [11:0] last_rgb = '0;

  always #5 CLK = ~CLK;

  vga_scan_driver u_dut (
    .CLK(CLK), .RST_N(RST_N), .PIX_EN(PIX_EN),
    .H_CNT(d_hcnt), .next_V_CNT(d_nextv), .NEXT_FRAME(d_nf), .H_BLANKING(d_hblank),
    .r(r), .g(g), .b(b),
    .VGA_R(d_vr), .VGA_G(d_vg), .VGA_B(d_vb), .VGA_HSYNC(d_hs), .VGA_VSYNC(d_vs)
  );

  vga_scan_driver #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FR), .H_SYNC(SH_SY), .H_BACK(SH_BK),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FR), .V_SYNC(SV_SY), .V_BACK(SV_BK),
    .PRODUCER_LAT(S_LAT)
  ) u_small (
    .CLK(CLK), .RST_N(RST_N), .PIX_EN(PIX_EN),
    .H_CNT(s_hcnt), .next_V_CNT(s_nextv), .NEXT_FRAME(s_nf), .H_BLANKING(s_hblank),
    .r(r), .g(g), .b(b),
    .VGA_R(s_vr), .VGA_G(s_vg), .VGA_B(s_vb), .VGA_HSYNC(s_hs), .VGA_VSYNC(s_vs)
  );

  function automatic int hp(input int cnt, input int ht);
    return cnt % ht;
  endfunction

  function automatic int vp(input int cnt, input int ht, input int vt);
    return (cnt / ht) % vt;
  endfunction

  // Pins {rgb, hsync, vsync} after cnt enabled edges; they show the position presented lat+1 edges ago.
  function automatic logic [13:0] pins(input int cnt, input int lat, input int hvis, input int hfr,
                                       input int hsy, input int ht, input int vvis, input int vfr,
                                       input int vsy, input int vt, input logic [11:0] rgb);
    int p, h, v;
    p = cnt - 1 - lat;
    if (p < 0) return {12'd0, 1'b1, 1'b1};
    h = hp(p, ht);
    v = vp(p, ht, vt);
    return {(h < hvis && v < vvis) ? rgb : 12'd0,
            !(h >= hvis + hfr && h < hvis + hfr + hsy),
            !(v >= vvis + vfr && v < vvis + vfr + vsy)};
  endfunction

  function automatic logic [13:0] d_pins(input int cnt, input logic [11:0] rgb);
    return pins(cnt, D_LAT, DH_VIS, DH_FR, DH_SY, DH_TOT, DV_VIS, DV_FR, DV_SY, DV_TOT, rgb);
  endfunction

  function automatic logic [13:0] s_pins(input int cnt, input logic [11:0] rgb);
    return pins(cnt, S_LAT, SH_VIS, SH_FR, SH_SY, SH_TOT, SV_VIS, SV_FR, SV_SY, SV_TOT, rgb);
  endfunction

  function automatic bit exp_nf(input int cnt, input bit en, input int ht, input int vt, input int vvis);
    return en && hp(cnt, ht) == 0 && vp(cnt, ht, vt) == vvis;
  endfunction

  task automatic tick(input bit en);
    if (cur_en) begin
      n++;
      last_rgb = pend_rgb;
    end
    @(negedge CLK);
    PIX_EN    = en;
    {r, g, b} = 12'($urandom);
    cur_en    = en;
    pend_rgb  = {r, g, b};
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N  = 1'b0;
    PIX_EN = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N  = 1'b1;
    n      = 0;
    cur_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    total += 2;
    if (d_hcnt !== 10'd0) begin bad++; $display("FAIL reset_in h_cnt got=%0d exp=0", d_hcnt); end
    if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== 14'h0003) begin
      bad++; $display("FAIL reset_in pins got=%h exp=0003", {d_vr, d_vg, d_vb, d_hs, d_vs});
    end
    do_reset();
    #1;
    total += 6;
    if (d_hcnt !== 10'd0)  begin bad++; $display("FAIL reset h_cnt got=%0d exp=0", d_hcnt); end
    if (d_nextv !== 10'd1) begin bad++; $display("FAIL reset next_v got=%0d exp=1", d_nextv); end
    if (d_hblank !== 1'b0) begin bad++; $display("FAIL reset h_blank got=%b exp=0", d_hblank); end
    if (d_nf !== 1'b0)     begin bad++; $display("FAIL reset next_frame got=%b exp=0", d_nf); end
    if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== 14'h0003) begin
      bad++; $display("FAIL reset pins got=%h exp=0003", {d_vr, d_vg, d_vb, d_hs, d_vs});
    end
    if ({s_nextv, s_vr, s_vg, s_vb, s_hs, s_vs} !== {10'd1, 14'h0003}) begin
      bad++; $display("FAIL reset small got=%h exp=%h", {s_nextv, s_vr, s_vg, s_vb, s_hs, s_vs}, {10'd1, 14'h0003});
    end
  endtask

  task automatic test_hscan();
    int          first_low = -1;
    int          low_cnt = 0;
    logic [13:0] ep;
    do_reset();
    for (int k = 0; k < 2 * DH_TOT + 40; k++) begin
      tick(1'b1);
      ep = d_pins(n, last_rgb);
      total += 5;
      if (d_hcnt !== 10'(hp(n, DH_TOT))) begin
        bad++; $display("FAIL hscan h_cnt n=%0d got=%0d exp=%0d", n, d_hcnt, hp(n, DH_TOT));
      end
      if (d_hblank !== (hp(n, DH_TOT) >= DH_VIS)) begin
        bad++; $display("FAIL hscan h_blank n=%0d got=%b", n, d_hblank);
      end
      if (d_nextv !== 10'((vp(n, DH_TOT, DV_TOT) + 1) % DV_TOT)) begin
        bad++; $display("FAIL hscan next_v n=%0d got=%0d", n, d_nextv);
      end
      if (d_nf !== exp_nf(n, 1'b1, DH_TOT, DV_TOT, DV_VIS)) begin
        bad++; $display("FAIL hscan next_frame n=%0d got=%b", n, d_nf);
      end
      if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== ep) begin
        bad++; $display("FAIL hscan pins n=%0d got=%h exp=%h", n, {d_vr, d_vg, d_vb, d_hs, d_vs}, ep);
      end
      if (k < DH_TOT && d_hs === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = int'(d_hcnt);
      end
    end
    total += 2;
    if (low_cnt != DH_SY) begin bad++; $display("FAIL hsync_width got=%0d exp=%0d", low_cnt, DH_SY); end
    if (first_low != DH_VIS + DH_FR + 2) begin
      bad++; $display("FAIL hsync_first got=%0d exp=%0d", first_low, DH_VIS + DH_FR + 2);
    end
  endtask

  task automatic test_pix_en();
    bit          en;
    logic [13:0] ep;
    do_reset();
    for (int k = 0; k < 3200; k++) begin
      en = (k < 1700) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
      tick(en);
      ep = d_pins(n, last_rgb);
      total += 5;
      if (d_hcnt !== 10'(hp(n, DH_TOT))) begin
        bad++; $display("FAIL pix_en h_cnt n=%0d got=%0d exp=%0d", n, d_hcnt, hp(n, DH_TOT));
      end
      if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== ep) begin
        bad++; $display("FAIL pix_en pins n=%0d got=%h exp=%h", n, {d_vr, d_vg, d_vb, d_hs, d_vs}, ep);
      end
      if (s_hcnt !== 10'(hp(n, SH_TOT))) begin
        bad++; $display("FAIL pix_en s_h_cnt n=%0d got=%0d exp=%0d", n, s_hcnt, hp(n, SH_TOT));
      end
      if (s_nf !== exp_nf(n, en, SH_TOT, SV_TOT, SV_VIS)) begin
        bad++; $display("FAIL pix_en s_next_frame n=%0d en=%b got=%b", n, en, s_nf);
      end
      if ({s_vr, s_vg, s_vb, s_hs, s_vs} !== s_pins(n, last_rgb)) begin
        bad++; $display("FAIL pix_en s_pins n=%0d got=%h exp=%h", n, {s_vr, s_vg, s_vb, s_hs, s_vs}, s_pins(n, last_rgb));
      end
    end
  endtask

  task automatic test_small_frame();
    int pulses = 0;
    int last_pulse = -1;
    do_reset();
    for (int k = 0; k < 3 * SH_TOT * SV_TOT + 10; k++) begin
      tick(1'b1);
      total += 5;
      if ({s_hcnt, s_hblank} !== {10'(hp(n, SH_TOT)), 1'(hp(n, SH_TOT) >= SH_VIS)}) begin
        bad++; $display("FAIL small h_cnt n=%0d got=%0d/%b exp=%0d", n, s_hcnt, s_hblank, hp(n, SH_TOT));
      end
      if (s_nextv !== 10'((vp(n, SH_TOT, SV_TOT) + 1) % SV_TOT)) begin
        bad++; $display("FAIL small next_v n=%0d got=%0d", n, s_nextv);
      end
      if (s_nf !== exp_nf(n, 1'b1, SH_TOT, SV_TOT, SV_VIS)) begin
        bad++; $display("FAIL small next_frame n=%0d got=%b", n, s_nf);
      end
      if ({s_vr, s_vg, s_vb, s_hs, s_vs} !== s_pins(n, last_rgb)) begin
        bad++; $display("FAIL small pins n=%0d got=%h exp=%h", n, {s_vr, s_vg, s_vb, s_hs, s_vs}, s_pins(n, last_rgb));
      end
      if (n == SH_TOT * SV_TOT - 1 && {s_hcnt, s_nextv} !== {10'(SH_TOT - 1), 10'd0}) begin
        bad++; $display("FAIL small wrap got=%0d/%0d exp=%0d/0", s_hcnt, s_nextv, SH_TOT - 1);
      end else if (n != SH_TOT * SV_TOT - 1 && s_nf === 1'b1 && last_pulse >= 0
                   && n - last_pulse != SH_TOT * SV_TOT) begin
        bad++; $display("FAIL small pulse_gap got=%0d exp=%0d", n - last_pulse, SH_TOT * SV_TOT);
      end
      if (s_nf === 1'b1) begin
        pulses++;
        last_pulse = n;
      end
    end
    total += 1;
    if (pulses != 3) begin bad++; $display("FAIL small pulse_count got=%0d exp=3", pulses); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 2 * DH_TOT + 124; k++) tick(1'b1);
    total += 1;
    if ({d_hcnt, d_nextv} !== {10'd123, 10'd3}) begin
      bad++; $display("FAIL mid pre got=%0d/%0d exp=123/3", d_hcnt, d_nextv);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      RST_N  = 1'b0;
      PIX_EN = 1'b1;
      #1;
      total += 3;
      if ({d_hcnt, d_nextv} !== {10'd0, 10'd1}) begin
        bad++; $display("FAIL mid_rst cnt k=%0d got=%0d/%0d exp=0/1", k, d_hcnt, d_nextv);
      end
      if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== 14'h0003) begin
        bad++; $display("FAIL mid_rst pins k=%0d got=%h exp=0003", k, {d_vr, d_vg, d_vb, d_hs, d_vs});
      end
      if ({d_nf, s_nf, s_hcnt} !== 12'd0) begin
        bad++; $display("FAIL mid_rst small k=%0d got=%b/%b/%0d exp=0", k, d_nf, s_nf, s_hcnt);
      end
    end
    @(negedge CLK);
    RST_N  = 1'b1;
    PIX_EN = 1'b0;
    n      = 0;
    cur_en = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1'b1);
      total += 3;
      if (d_hcnt !== 10'(hp(n, DH_TOT))) begin
        bad++; $display("FAIL mid_after h_cnt n=%0d got=%0d exp=%0d", n, d_hcnt, hp(n, DH_TOT));
      end
      if ({d_vr, d_vg, d_vb, d_hs, d_vs} !== d_pins(n, last_rgb)) begin
        bad++; $display("FAIL mid_after pins n=%0d got=%h", n, {d_vr, d_vg, d_vb, d_hs, d_vs});
      end
      if (s_nf !== exp_nf(n, 1'b1, SH_TOT, SV_TOT, SV_VIS)) begin
        bad++; $display("FAIL mid_after s_next_frame n=%0d got=%b", n, s_nf);
      end
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    PIX_EN = 1'b0;
    r = '0;
    g = '0;
    b = '0;
    test_reset();
    test_hscan();
    test_pix_en();
    test_small_frame();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
